bb_frame_decoder: RTL
=====================

Name: bb_frame_decoder

Overview:
- Far-end decoder for the bus-bridge UART link: takes deserialized bytes from a UART receiver and reassembles bridge request frames.
- Each complete frame is presented to the local bus-bridge master as one read or write request, through a valid/ready handshake.
- It is the receiving counterpart of the frame encoder that sits behind the bridge slave's UART transmitter.

Parameters:
- DATA_WIDTH, 8, bus data width; the payload is exactly one byte.
- BB_ADDR_WIDTH, 13, bridged address width; carried as 2 bytes, MSB first; unused upper bits are ignored.
- TIMEOUT_CYCLES, 20000, maximum clk cycles allowed between bytes of one frame.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- rx_data  in  8  byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_data is valid.
- rx_err  in  1  one-cycle strobe; stop-bit/framing error on the current byte.
- req_valid  out  1  decoded request pending.
- req_ready  in  1  bridge master accepts the request.
- req_mode  out  1  1 = write, 0 = read.
- req_addr  out  BB_ADDR_WIDTH  request address.
- req_wdata  out  DATA_WIDTH  write data; 0 for reads.
- frame_err  out  1  one-cycle pulse; frame discarded.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Frame format:
  - Header byte: [7:4] = 4'hA sync nibble; [0] = mode; [3:1] ignored.
  - Then ADDR_HI, then ADDR_LO.
  - Write frames add one DATA byte; read frames end after ADDR_LO.
- States: IDLE, ADDR_HI, ADDR_LO, DATA, HOLD.
- IDLE:
  - rx_valid with header[7:4] == 4'hA: latch mode, go to ADDR_HI.
  - Any other byte: discarded silently (resync); no frame_err.
- ADDR_HI / ADDR_LO: on rx_valid, shift the byte into the address register.
  - After ADDR_LO: go to DATA if mode = 1, else to HOLD.
- DATA: on rx_valid, latch req_wdata, go to HOLD.
- HOLD:
  - req_valid = 1 from the cycle after the final byte's rx_valid (1-cycle latency).
  - req_mode, req_addr and req_wdata are stable while req_valid = 1.
  - On req_valid && req_ready: req_valid drops next cycle; go to IDLE.
  - Same-cycle acceptance is permitted.
- Overrun: rx_valid while in HOLD drops the byte and pulses frame_err. The held request is kept and still completes.
- rx_err:
  - In ADDR_HI, ADDR_LO or DATA: abort, pulse frame_err, go to IDLE.
  - In IDLE: ignored.
  - In HOLD: treated as overrun (frame_err pulse, request kept).
- rx_valid and rx_err in the same cycle: rx_err wins; the byte is dropped.
- Timeout:
  - Counter clears on every accepted byte.
  - Counts only in ADDR_HI, ADDR_LO and DATA.
  - Reaching TIMEOUT_CYCLES-1: pulse frame_err, go to IDLE.
  - Never times out in HOLD; the counter is held at 0 there.
- Counter width: $clog2(TIMEOUT_CYCLES); it must not wrap.
- Address: req_addr = {ADDR_HI, ADDR_LO}[BB_ADDR_WIDTH-1:0].
- Reset (any time, including mid-frame or in HOLD), applied asynchronously:
  - state IDLE, req_valid 0, req_mode 0, req_addr 0, req_wdata 0, frame_err 0, busy 0, timeout counter 0.
  - A partial frame is lost.

Decomposition:
- Shared bridge package holds:
  - SYNC_NIBBLE = 4'hA.
  - MODE_READ = 0, MODE_WRITE = 1.
  - Frame state enum.
  - Frame byte counts: read 3, write 4.
- The encoder on the bridge-slave side uses the same package.
- Optional sub-module: bb_byte_timeout (loadable down-counter with clear/enable and expire pulse); the remaining FSM stays in this module.

Test Plan:
- Write frame A5 ; 1A ; BC ; 3C with req_ready = 1 -> after the 4th byte: one req_valid cycle, req_mode 1, req_addr 0x1ABC, req_wdata 0x3C; busy back to 0.
- Read frame A0 ; 00 ; 42 with req_ready = 0 for 10 cycles -> req_valid held 10 cycles with req_mode 0, req_addr 0x0042, req_wdata 0x00; clears the cycle after req_ready = 1.
- Garbage 55, FF, then A1 ; 00 ; 01 ; 7E -> first two bytes ignored, no frame_err; request: addr 0x0001, data 0x7E, mode 1.
- A1 ; 12, then idle TIMEOUT_CYCLES cycles -> one frame_err pulse, no req_valid.
  - Next full frame decodes normally.
- A1 ; 12 ; rx_err asserted with rx_valid -> frame_err, state IDLE, no request.
  - Also: rx_valid during HOLD with req_ready = 0 -> frame_err pulse; the original request is unchanged and completes.
- rstn asserted asynchronously after byte 2 of a write frame -> all outputs 0 immediately.
  - After release, a fresh A0 ; 00 ; 10 yields a read of 0x0010.

Source files
------------

// File: rtl/bb_frame_decoder_pkg.sv
// Shared bus-bridge UART link definitions: frame header sync nibble, mode
// encoding, decoder state encoding and per-frame byte counts. Used by both the
// far-end frame decoder and the bridge-slave frame encoder.
package bb_frame_decoder_pkg;

  localparam logic [3:0] SYNC_NIBBLE       = 4'hA;
  localparam logic       MODE_READ         = 1'b0;
  localparam logic       MODE_WRITE        = 1'b1;
  localparam int         READ_FRAME_BYTES  = 3;
  localparam int         WRITE_FRAME_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR_HI = 3'd1,
    ST_ADDR_LO = 3'd2,
    ST_DATA    = 3'd3,
    ST_HOLD    = 3'd4
  } bb_frame_state_e;

  // True when the byte carries the frame header sync nibble in its upper half.
  function automatic logic is_header(input logic [7:0] b);
    return (b[7:4] == SYNC_NIBBLE);
  endfunction

endpackage

// File: rtl/bb_frame_decoder_timeout.sv
// Inter-byte timeout for the frame decoder. Counts elapsed cycles while
// enabled, restarts from zero on clear, and sits at zero while disabled.
// The count saturates at LIMIT-1 and expire is raised while it sits there.
module bb_frame_decoder_timeout #(
  parameter int LIMIT = 20000
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CNT_W = $clog2(LIMIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear on byte, zero when idle or holding, saturate at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/bb_frame_decoder.sv
// Far-end bus-bridge frame decoder. Reassembles header / address / optional
// data bytes from the UART receiver into one read or write request for the
// local bridge master, presented through a valid/ready handshake.
module bb_frame_decoder
  import bb_frame_decoder_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int BB_ADDR_WIDTH  = 13,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  input  logic                     rx_err,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic                     req_mode,
  output logic [BB_ADDR_WIDTH-1:0] req_addr,
  output logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     frame_err,
  output logic                     busy
);

  bb_frame_state_e state_q, state_d;

  logic                     mode_q, mode_d;
  logic [BB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     frame_err_q, frame_err_d;

  logic byte_ok_s;
  logic in_frame_s;
  logic tmo_expire_s;

  // A byte only counts when it arrived without a framing error.
  assign byte_ok_s  = rx_valid && !rx_err;
  assign in_frame_s = (state_q == ST_ADDR_HI) || (state_q == ST_ADDR_LO) ||
                      (state_q == ST_DATA);

  bb_frame_decoder_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (byte_ok_s),
    .en     (in_frame_s),
    .expire (tmo_expire_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and frame error: rx_err beats a byte, a byte beats the timeout.
  always_comb begin
    state_d     = state_q;
    frame_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (byte_ok_s && is_header(rx_data)) begin
          state_d = ST_ADDR_HI;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR_HI, ST_ADDR_LO, ST_DATA: begin
        if (rx_err) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end else if (rx_valid) begin
          if (state_q == ST_ADDR_HI) begin
            state_d = ST_ADDR_LO;
          end else if (state_q == ST_ADDR_LO) begin
            state_d = (mode_q == MODE_WRITE) ? ST_DATA : ST_HOLD;
          end else begin
            state_d = ST_HOLD;
          end
        end else if (tmo_expire_s) begin
          state_d     = ST_IDLE;
          frame_err_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_HOLD: begin
        // Any byte arriving while a request is pending is an overrun.
        frame_err_d = rx_valid || rx_err;
        if (req_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request fields: captured only from good bytes, frozen while holding.
  always_comb begin
    mode_d  = mode_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (byte_ok_s && is_header(rx_data)) begin
          mode_d  = rx_data[0];
          wdata_d = '0;
        end else begin
          mode_d = mode_q;
        end
      end
      ST_ADDR_HI, ST_ADDR_LO: begin
        if (byte_ok_s) begin
          addr_d = {addr_q[BB_ADDR_WIDTH-9:0], rx_data};
        end else begin
          addr_d = addr_q;
        end
      end
      ST_DATA: begin
        if (byte_ok_s) begin
          wdata_d = rx_data[DATA_WIDTH-1:0];
        end else begin
          wdata_d = wdata_q;
        end
      end
      default: begin
        mode_d = mode_q;
      end
    endcase
  end

  // Request field and frame error registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q      <= MODE_READ;
      addr_q      <= '0;
      wdata_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    req_valid = (state_q == ST_HOLD);
    busy      = (state_q != ST_IDLE);
    req_mode  = mode_q;
    req_addr  = addr_q;
    req_wdata = wdata_q;
    frame_err = frame_err_q;
  end

endmodule
